// File: rtl/clk_en_sched_if.sv
// Bundle of hold/resync controls and enable/status outputs of clk_en_sched.
// CLK_EN_SCHED_LEVEL_EN adds the 50% duty level-clock outputs.
interface clk_en_sched_if;
  logic       hold;
  logic       resync_req;
  logic       en_4f;
  logic       en_2f;
  logic       en_f;
  logic [4:0] phase;
  logic       clk_ok;
  logic       resync_ack;
  logic [1:0] state;
`ifdef CLK_EN_SCHED_LEVEL_EN
  logic       clk_4f_lvl;
  logic       clk_2f_lvl;
  logic       clk_f_lvl;

  modport slave (
    input  hold, resync_req,
    output en_4f, en_2f, en_f, phase, clk_ok, resync_ack, state,
    output clk_4f_lvl, clk_2f_lvl, clk_f_lvl
  );
  modport master (
    output hold, resync_req,
    input  en_4f, en_2f, en_f, phase, clk_ok, resync_ack, state,
    input  clk_4f_lvl, clk_2f_lvl, clk_f_lvl
  );
`else
  modport slave (
    input  hold, resync_req,
    output en_4f, en_2f, en_f, phase, clk_ok, resync_ack, state
  );
  modport master (
    output hold, resync_req,
    input  en_4f, en_2f, en_f, phase, clk_ok, resync_ack, state
  );
`endif
endinterface

// File: rtl/clk_en_sched.sv
// Derives 4f/2f/f enable strobes from a 32f bit clock with warm-up and resync FSM.
// Optional level clocks via macro CLK_EN_SCHED_LEVEL_EN.
module clk_en_sched #(
  parameter int unsigned WARM_PERIODS = 4
) (
  input  logic           clk_32f,
  input  logic           reset,
  clk_en_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARM   = 2'd1,
    RUN    = 2'd2,
    RESYNC = 2'd3
  } state_t;

  localparam logic [3:0] WARM_TARGET = 4'(WARM_PERIODS);

  state_t     state_reg, state_next;
  logic [4:0] phase_reg, phase_next;
  logic [3:0] warm_reg, warm_next;
  logic       clk_ok_reg, clk_ok_next;
  logic       ack_reg, ack_next;
  logic       resync_prev_reg;
  logic       counting;
  logic       resync_edge;
  logic [2:0] strobe;

  assign counting    = (state_reg == WARM) || (state_reg == RUN);
  assign resync_edge = bus.resync_req & ~resync_prev_reg;

  // strobe[gi] fires when the low gi+3 phase bits are all ones
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_strobe
      assign strobe[gi] = counting & ~bus.hold & (&phase_reg[gi+2:0]);
    end
  endgenerate

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      phase_reg       <= 5'd0;
      warm_reg        <= 4'd0;
      clk_ok_reg      <= 1'b0;
      ack_reg         <= 1'b0;
      resync_prev_reg <= 1'b0;
    end else begin
      phase_reg       <= phase_next;
      warm_reg        <= warm_next;
      clk_ok_reg      <= clk_ok_next;
      ack_reg         <= ack_next;
      resync_prev_reg <= bus.resync_req;
    end
  end

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    warm_next   = warm_reg;
    clk_ok_next = clk_ok_reg;
    ack_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = WARM;
      end
      WARM, RUN: begin
        // a resync edge wins over a coincident en_f, which then goes uncounted
        if (resync_edge) begin
          state_next  = RESYNC;
          phase_next  = 5'd0;
          warm_next   = 4'd0;
          clk_ok_next = 1'b0;
          ack_next    = 1'b1;
        end else begin
          if (!bus.hold) begin
            phase_next = phase_reg + 5'd1;
          end
          if ((state_reg == WARM) && strobe[2]) begin
            warm_next = warm_reg + 4'd1;
            if (warm_reg + 4'd1 == WARM_TARGET) begin
              state_next  = RUN;
              clk_ok_next = 1'b1;
            end
          end
        end
      end
      RESYNC: begin
        state_next = WARM;
        phase_next = 5'd0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.en_4f      = strobe[0];
  assign bus.en_2f      = strobe[1];
  assign bus.en_f       = strobe[2];
  assign bus.phase      = phase_reg;
  assign bus.clk_ok     = clk_ok_reg;
  assign bus.resync_ack = ack_reg;
  assign bus.state      = state_reg;

`ifdef CLK_EN_SCHED_LEVEL_EN
  assign bus.clk_4f_lvl = phase_reg[2];
  assign bus.clk_2f_lvl = phase_reg[3];
  assign bus.clk_f_lvl  = phase_reg[4];
`else
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed self-checking bench for clk_en_sched (WARM_PERIODS=4).
module tb_clk_en_sched;

  logic clk_32f = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_32f = ~clk_32f;

  clk_en_sched_if bus();

  clk_en_sched #(.WARM_PERIODS(4)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // strobe pattern for an unheld, counting phase value p
  task automatic check_strobes(input string tag, input int p);
    check({tag, "_en4f"}, bus.en_4f, ((p % 8) == 7) ? 1 : 0);
    check({tag, "_en2f"}, bus.en_2f, ((p % 16) == 15) ? 1 : 0);
    check({tag, "_enf"},  bus.en_f,  (p == 31) ? 1 : 0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.hold       = 1'b0;
    bus.resync_req = 1'b0;
    repeat (3) tick();
    $display("[tb] reset held 3 cycles");
    check("rst_state", bus.state, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_clk_ok", bus.clk_ok, 0);
    check("rst_ack", bus.resync_ack, 0);
    check("rst_strobes", {bus.en_4f, bus.en_2f, bus.en_f}, 0);
`ifdef CLK_EN_SCHED_LEVEL_EN
    check("rst_lvl", {bus.clk_4f_lvl, bus.clk_2f_lvl, bus.clk_f_lvl}, 0);
`endif

    // release with a resync edge present while IDLE: must be ignored
    reset          = 1'b1;
    bus.resync_req = 1'b1;
    tick();
    $display("[tb] reset released, IDLE -> WARM");
    check("warm_entry_state", bus.state, 1);
    check("warm_entry_phase", bus.phase, 0);
    check("warm_entry_ack", bus.resync_ack, 0);
    for (int k = 0; k < 32; k++) begin
      if (k == 2) bus.resync_req = 1'b0;
      if (k == 1) check("idle_edge_ignored", bus.state, 1);
      check("p1_phase", bus.phase, k);
      check_strobes("p1", k);
      tick();
    end
    check("p1_wrap", bus.phase, 0);

    repeat (95) tick();
    $display("[tb] fourth en_f of warm-up");
    check("warm4_phase", bus.phase, 31);
    check("warm4_state", bus.state, 1);
    check("warm4_enf", bus.en_f, 1);
    check("warm4_clk_ok", bus.clk_ok, 0);
    tick();
    check("run_state", bus.state, 2);
    check("run_clk_ok", bus.clk_ok, 1);
    check("run_phase", bus.phase, 0);

    repeat (5) tick();
    check("hold_start_phase", bus.phase, 5);
    bus.hold = 1'b1;
    $display("[tb] hold for 10 cycles at phase 5");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_phase", bus.phase, 5);
      check("hold_clk_ok", bus.clk_ok, 1);
      check("hold_strobes", {bus.en_4f, bus.en_2f, bus.en_f}, 0);
    end
    bus.hold = 1'b0;
    tick();
    check("hold_resume", bus.phase, 6);
    tick();
    check("p7_en4f", bus.en_4f, 1);
    bus.hold = 1'b1;
    #1;
    check("p7_hold_gate", bus.en_4f, 0);
    tick();
    check("p7_frozen", bus.phase, 7);
    bus.hold = 1'b0;
    #1;
    check("p7_ungate", bus.en_4f, 1);
    tick();
    check("p8_phase", bus.phase, 8);

    bus.resync_req = 1'b1;
    tick();
    $display("[tb] resync request in RUN");
    check("rs1_state", bus.state, 3);
    check("rs1_ack", bus.resync_ack, 1);
    check("rs1_phase", bus.phase, 0);
    check("rs1_clk_ok", bus.clk_ok, 0);
    tick();
    check("rs1_warm", bus.state, 1);
    check("rs1_ack_drop", bus.resync_ack, 0);
    check("rs1_warm_phase", bus.phase, 0);
    for (int i = 1; i <= 18; i++) begin
      tick();
      check("rs1_no_retrig", bus.resync_ack, 0);
      check("rs1_hold_state", bus.state, 1);
      check("rs1_count", bus.phase, i);
    end
    bus.resync_req = 1'b0;
    tick();
    bus.resync_req = 1'b1;
    tick();
    $display("[tb] second resync request after low sample");
    check("rs2_state", bus.state, 3);
    check("rs2_ack", bus.resync_ack, 1);
    bus.hold = 1'b1;
    tick();
    check("rs2_hold_warm", bus.state, 1);
    check("rs2_hold_phase", bus.phase, 0);
    check("rs2_ack_drop", bus.resync_ack, 0);
    bus.hold       = 1'b0;
    bus.resync_req = 1'b0;

    repeat (96) tick();
    check("w3_state", bus.state, 1);
    repeat (31) tick();
    check("w3_phase", bus.phase, 31);
    check("w3_enf", bus.en_f, 1);
    bus.resync_req = 1'b1;
    tick();
    $display("[tb] resync coinciding with en_f after 3 periods");
    check("rs3_state", bus.state, 3);
    check("rs3_clk_ok", bus.clk_ok, 0);
    tick();
    check("rs3_warm", bus.state, 1);
    check("rs3_phase", bus.phase, 0);
    bus.resync_req = 1'b0;
    repeat (96) tick();
    check("rs3_still_warm", bus.state, 1);
    repeat (31) tick();
    check("rs3_p31_warm", bus.state, 1);
    check("rs3_p31_phase", bus.phase, 31);
    tick();
    check("rs3_run", bus.state, 2);
    check("rs3_run_clk_ok", bus.clk_ok, 1);

    repeat (17) tick();
    check("mid_phase", bus.phase, 17);
`ifdef CLK_EN_SCHED_LEVEL_EN
    check("mid_lvl", {bus.clk_4f_lvl, bus.clk_2f_lvl, bus.clk_f_lvl}, 3'b001);
`endif
    reset = 1'b0;
    tick();
    $display("[tb] reset asserted in RUN at phase 17");
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_phase", bus.phase, 0);
    check("mid_rst_clk_ok", bus.clk_ok, 0);
    check("mid_rst_ack", bus.resync_ack, 0);
`ifdef CLK_EN_SCHED_LEVEL_EN
    check("mid_rst_lvl", {bus.clk_4f_lvl, bus.clk_2f_lvl, bus.clk_f_lvl}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
